// File: rtl/scan_ascii_fifo.sv
// scan_ascii_fifo: PS/2 key events to ASCII with Shift/Caps tracking, typematic filter and FWFT character queue
module scan_ascii_fifo #(
  parameter int FIFO_AW = 3,
  parameter int UPPER_EN = 1,
  parameter int REPEAT_FILTER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [9:0]       code,
  input  logic             char_ready,
  output logic             char_valid,
  output logic [7:0]       char,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow,
  output logic             shift_state,
  output logic             caps_state
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT1 = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR1 = FIFO_AW'(1);
  logic [7:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0] r_count;
  logic r_lsh, r_rsh, r_caps, r_ovf;
  logic r_held_v, r_held_e;
  logic [7:0] r_held_s;
  logic w_ext, w_brk, w_make, w_held_hit, w_shift, w_upper;
  logic w_letter, w_digit, w_push, w_pop, w_full, w_write;
  logic [7:0] w_scan, w_base, w_sym, w_ascii;
  assign w_ext = code[9];
  assign w_brk = code[8];
  assign w_scan = code[7:0];
  assign w_make = code_valid & ~w_brk;
  assign w_held_hit = r_held_v & (r_held_e == w_ext) & (r_held_s == w_scan);
  assign w_shift = r_lsh | r_rsh;
  assign w_upper = (UPPER_EN != 0) & (w_shift ^ r_caps);
  assign w_letter = (w_base >= 8'h61) & (w_base <= 8'h7A);
  assign w_digit = (w_base >= 8'h30) & (w_base <= 8'h39);
  assign w_ascii = (w_letter & w_upper) ? w_base - 8'h20 :
                   (w_digit & (UPPER_EN != 0) & w_shift) ? w_sym : w_base;
  assign w_push = w_make & (w_base != 8'h00) & ~((REPEAT_FILTER != 0) & w_held_hit);
  assign w_pop = (r_count != '0) & char_ready;
  assign w_full = r_count == FULL;
  assign w_write = w_push & (~w_full | w_pop);
  assign char_valid = r_count != '0;
  assign char = char_valid ? r_mem[r_rp] : 8'h00;
  assign fifo_count = r_count;
  assign overflow = r_ovf;
  assign shift_state = w_shift;
  assign caps_state = r_caps;
  // Unshifted lookup; modifiers and unknown codes stay 00 so they never enqueue
  always_comb begin
    w_base = 8'h00;
    if (w_ext) begin
      case (w_scan)
        8'h74: w_base = 8'h1C;
        8'h6B: w_base = 8'h1D;
        8'h75: w_base = 8'h1E;
        8'h72: w_base = 8'h1F;
        default: w_base = 8'h00;
      endcase
    end else begin
      case (w_scan)
        8'h1C: w_base = 8'h61;
        8'h32: w_base = 8'h62;
        8'h21: w_base = 8'h63;
        8'h23: w_base = 8'h64;
        8'h24: w_base = 8'h65;
        8'h2B: w_base = 8'h66;
        8'h34: w_base = 8'h67;
        8'h33: w_base = 8'h68;
        8'h43: w_base = 8'h69;
        8'h3B: w_base = 8'h6A;
        8'h42: w_base = 8'h6B;
        8'h4B: w_base = 8'h6C;
        8'h3A: w_base = 8'h6D;
        8'h31: w_base = 8'h6E;
        8'h44: w_base = 8'h6F;
        8'h4D: w_base = 8'h70;
        8'h15: w_base = 8'h71;
        8'h2D: w_base = 8'h72;
        8'h1B: w_base = 8'h73;
        8'h2C: w_base = 8'h74;
        8'h3C: w_base = 8'h75;
        8'h2A: w_base = 8'h76;
        8'h1D: w_base = 8'h77;
        8'h22: w_base = 8'h78;
        8'h35: w_base = 8'h79;
        8'h1A: w_base = 8'h7A;
        8'h45: w_base = 8'h30;
        8'h16: w_base = 8'h31;
        8'h1E: w_base = 8'h32;
        8'h26: w_base = 8'h33;
        8'h25: w_base = 8'h34;
        8'h2E: w_base = 8'h35;
        8'h36: w_base = 8'h36;
        8'h3D: w_base = 8'h37;
        8'h3E: w_base = 8'h38;
        8'h46: w_base = 8'h39;
        8'h29: w_base = 8'h20;
        8'h5A: w_base = 8'h0D;
        8'h66: w_base = 8'h08;
        8'h76: w_base = 8'h1B;
        default: w_base = 8'h00;
      endcase
    end
  end
  // Shifted digit symbols, indexed by the unshifted digit value
  always_comb begin
    w_sym = 8'h00;
    case (w_base[3:0])
      4'd0: w_sym = 8'h29;
      4'd1: w_sym = 8'h21;
      4'd2: w_sym = 8'h40;
      4'd3: w_sym = 8'h23;
      4'd4: w_sym = 8'h24;
      4'd5: w_sym = 8'h25;
      4'd6: w_sym = 8'h5E;
      4'd7: w_sym = 8'h26;
      4'd8: w_sym = 8'h2A;
      4'd9: w_sym = 8'h28;
      default: w_sym = 8'h00;
    endcase
  end
  // Modifier flags and held key; Caps only toggles on a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lsh <= 1'b0;
      r_rsh <= 1'b0;
      r_caps <= 1'b0;
      r_held_v <= 1'b0;
      r_held_e <= 1'b0;
      r_held_s <= 8'h00;
    end else if (code_valid) begin
      if (!w_brk) begin
        if (!w_held_hit) {r_held_v, r_held_e, r_held_s} <= {1'b1, w_ext, w_scan};
        if (!w_ext && w_scan == 8'h12) r_lsh <= 1'b1;
        if (!w_ext && w_scan == 8'h59) r_rsh <= 1'b1;
        if (!w_ext && w_scan == 8'h58 && !w_held_hit) r_caps <= ~r_caps;
      end else begin
        if (w_held_hit) r_held_v <= 1'b0;
        if (!w_ext && w_scan == 8'h12) r_lsh <= 1'b0;
        if (!w_ext && w_scan == 8'h59) r_rsh <= 1'b0;
      end
    end
  end
  // Queue pointers, occupancy and sticky overflow; a full queue accepts a push only alongside a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_write) r_wp <= r_wp + PTR1;
      if (w_pop) r_rp <= r_rp + PTR1;
      r_count <= (w_write & ~w_pop) ? r_count + CNT1 : (~w_write & w_pop) ? r_count - CNT1 : r_count;
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
    end
  end
  // Character storage
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wp] <= w_ascii;
  end
endmodule

// File: tb/tb_scan_ascii_fifo.sv
// tb_scan_ascii_fifo: directed and random checks of two converter instances (repeat filter on/off) against a queue model
module tb_scan_ascii_fifo;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, code_valid = 0, char_ready = 0;
  logic [9:0] code = '0;
  logic v0, v1, ov0, ov1, sh0, sh1, cp0, cp1;
  logic [7:0] c0, c1;
  logic [AW:0] n0, n1;
  int checks = 0, fails = 0;
  byte unsigned q0[$], q1[$];
  bit m_ls, m_rs, m_caps, m_hv, m_he, m_ov0, m_ov1;
  logic [7:0] m_hs;
  byte unsigned lower_tbl[int];
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
    8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool [18] = '{8'h1C, 8'h1D, 8'h16, 8'h1E, 8'h45, 8'h12, 8'h59, 8'h58, 8'h29,
    8'h5A, 8'h66, 8'h76, 8'h74, 8'h75, 8'h6B, 8'h72, 8'h0E, 8'h32};

  always #5 clk = ~clk;

  scan_ascii_fifo #(.FIFO_AW(AW), .UPPER_EN(1), .REPEAT_FILTER(1)) dut0 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .char_ready(char_ready),
    .char_valid(v0), .char(c0), .fifo_count(n0), .overflow(ov0), .shift_state(sh0), .caps_state(cp0));
  scan_ascii_fifo #(.FIFO_AW(AW), .UPPER_EN(1), .REPEAT_FILTER(0)) dut1 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .char_ready(char_ready),
    .char_valid(v1), .char(c1), .fifo_count(n1), .overflow(ov1), .shift_state(sh1), .caps_state(cp1));

  function automatic logic [7:0] xlate(input logic ext, input logic [7:0] sc);
    string shifted = ")!@#$%^&*(";
    logic [7:0] c;
    bit sh = m_ls | m_rs;
    if (ext) return sc == 8'h74 ? 8'h1C : sc == 8'h6B ? 8'h1D : sc == 8'h75 ? 8'h1E : sc == 8'h72 ? 8'h1F : 8'h00;
    if (!lower_tbl.exists(int'(sc))) return 8'h00;
    c = lower_tbl[int'(sc)];
    if (c >= 8'h61 && c <= 8'h7A && (sh ^ m_caps)) c = c - 8'h20;
    else if (c >= 8'h30 && c <= 8'h39 && sh) c = shifted[c - 8'h30];
    return c;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    {m_ls, m_rs, m_caps, m_hv, m_he, m_ov0, m_ov1} = '0;
    m_hs = 8'h00;
  endtask

  task automatic model_event(input logic [9:0] c);
    logic [7:0] ch;
    bit same = m_hv && m_he == c[9] && m_hs == c[7:0];
    if (!c[8]) begin
      ch = xlate(c[9], c[7:0]);
      if (ch != 8'h00) begin
        if (!same) begin
          if (q0.size() == DEPTH) m_ov0 = 1; else q0.push_back(ch);
        end
        if (q1.size() == DEPTH) m_ov1 = 1; else q1.push_back(ch);
      end
      if (!c[9] && c[7:0] == 8'h12) m_ls = 1;
      if (!c[9] && c[7:0] == 8'h59) m_rs = 1;
      if (!c[9] && c[7:0] == 8'h58 && !same) m_caps = ~m_caps;
      if (!same) begin
        m_hv = 1; m_he = c[9]; m_hs = c[7:0];
      end
    end else begin
      if (same) m_hv = 0;
      if (!c[9] && c[7:0] == 8'h12) m_ls = 0;
      if (!c[9] && c[7:0] == 8'h59) m_rs = 0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [9:0] c, input logic rdy);
    rst = r; code_valid = v; code = c; char_ready = rdy;
    if (r) model_reset();
    else begin
      if (rdy && q0.size() > 0) void'(q0.pop_front());
      if (rdy && q1.size() > 0) void'(q1.pop_front());
      if (v) model_event(c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(1, 0, 10'h000, 0);
    step(1, 1, 10'h01C, 1);
    checks++; if ({v0, c0, n0} !== '0) begin fails++; $display("FAIL reset_fifo: valid=%b char=%h count=%0d want 0/00/0", v0, c0, n0); end
    checks++; if ({ov0, sh0, cp0} !== 3'b000) begin fails++; $display("FAIL reset_flags: ovf=%b shift=%b caps=%b want 000", ov0, sh0, cp0); end
    checks++; if ({v1, n1} !== '0) begin fails++; $display("FAIL reset_dut1: valid=%b count=%0d want 0/0", v1, n1); end
  endtask

  task automatic test_basic();
    step(0, 1, 10'h01C, 0);
    checks++; if ({v0, c0, n0} !== {1'b1, 8'h61, 4'd1}) begin fails++; $display("FAIL basic_push: valid=%b char=%h count=%0d want 1/61/1", v0, c0, n0); end
    step(0, 0, 10'h000, 1);
    checks++; if ({v0, c0, n0} !== '0) begin fails++; $display("FAIL basic_pop: valid=%b char=%h count=%0d want 0/00/0", v0, c0, n0); end
  endtask

  task automatic test_shift_caps();
    logic [9:0] seq [10] = '{10'h012, 10'h01C, 10'h11C, 10'h112, 10'h01C, 10'h058, 10'h158, 10'h016, 10'h012, 10'h016};
    logic [7:0] exp [4] = '{8'h41, 8'h61, 8'h31, 8'h21};
    foreach (seq[i]) step(0, 1, seq[i], 0);
    checks++; if (n0 !== 4'd4) begin fails++; $display("FAIL shift_count: got %0d want 4", n0); end
    checks++; if ({sh0, cp0} !== 2'b11) begin fails++; $display("FAIL shift_flags: shift=%b caps=%b want 1/1", sh0, cp0); end
    foreach (exp[i]) begin
      checks++; if (c0 !== exp[i]) begin fails++; $display("FAIL shift_char%0d: got %h want %h", i, c0, exp[i]); end
      step(0, 0, 10'h000, 1);
    end
    step(0, 1, 10'h112, 0);
    step(0, 1, 10'h058, 0);
    step(0, 1, 10'h058, 0);
    step(0, 1, 10'h158, 0);
    checks++; if ({sh0, cp0, v0} !== 3'b000) begin fails++; $display("FAIL shift_release: shift=%b caps=%b valid=%b want 000", sh0, cp0, v0); end
  endtask

  task automatic test_repeat();
    logic [9:0] seq [5] = '{10'h01D, 10'h01D, 10'h01D, 10'h11D, 10'h01D};
    foreach (seq[i]) step(0, 1, seq[i], 0);
    checks++; if (n0 !== 4'd2) begin fails++; $display("FAIL repeat_filtered: got %0d want 2", n0); end
    checks++; if (n1 !== 4'd4) begin fails++; $display("FAIL repeat_unfiltered: got %0d want 4", n1); end
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        checks++; if (c0 !== 8'h77) begin fails++; $display("FAIL repeat_char0_%0d: got %h want 77", i, c0); end
      end
      checks++; if (c1 !== 8'h77) begin fails++; $display("FAIL repeat_char1_%0d: got %h want 77", i, c1); end
      step(0, 0, 10'h000, 1);
    end
    checks++; if ({v0, v1} !== 2'b00) begin fails++; $display("FAIL repeat_drain: valid0=%b valid1=%b want 0/0", v0, v1); end
  endtask

  task automatic test_ext();
    step(0, 1, 10'h274, 0);
    checks++; if ({c0, n0} !== {8'h1C, 4'd1}) begin fails++; $display("FAIL ext_right: char=%h count=%0d want 1C/1", c0, n0); end
    step(0, 1, 10'h275, 0);
    step(0, 1, 10'h374, 0);
    step(0, 1, 10'h00E, 0);
    checks++; if (n0 !== 4'd2) begin fails++; $display("FAIL ext_filter: count=%0d want 2", n0); end
    step(0, 0, 10'h000, 1);
    checks++; if (c0 !== 8'h1E) begin fails++; $display("FAIL ext_up: got %h want 1E", c0); end
    step(0, 0, 10'h000, 1);
  endtask

  task automatic test_overflow();
    string exp = "bcdefghj";
    for (int i = 0; i < 9; i++) step(0, 1, {2'b00, letter_sc[i]}, 0);
    checks++; if ({n0, ov0} !== {4'd8, 1'b1}) begin fails++; $display("FAIL ovf_full: count=%0d ovf=%b want 8/1", n0, ov0); end
    checks++; if ({n1, ov1} !== {4'd8, 1'b1}) begin fails++; $display("FAIL ovf_full1: count=%0d ovf=%b want 8/1", n1, ov1); end
    step(0, 1, 10'h03B, 1);
    checks++; if (n0 !== 4'd8) begin fails++; $display("FAIL ovf_pushpop: count=%0d want 8", n0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (c0 !== exp[i]) begin fails++; $display("FAIL ovf_order%0d: got %h want %h", i, c0, exp[i]); end
      step(0, 0, 10'h000, 1);
    end
    checks++; if ({v0, ov0} !== 2'b01) begin fails++; $display("FAIL ovf_sticky: valid=%b ovf=%b want 0/1", v0, ov0); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 10'h000, 0);
    for (int i = 0; i < 5; i++) step(0, 1, {2'b00, letter_sc[i]}, 0);
    step(0, 1, 10'h012, 0);
    step(0, 1, 10'h058, 0);
    checks++; if ({n0, sh0, cp0} !== {4'd5, 2'b11}) begin fails++; $display("FAIL mid_setup: count=%0d shift=%b caps=%b want 5/1/1", n0, sh0, cp0); end
    step(1, 1, 10'h01C, 1);
    checks++; if ({v0, c0, n0, ov0, sh0, cp0} !== '0) begin fails++; $display("FAIL mid_reset: valid=%b char=%h count=%0d ovf=%b shift=%b caps=%b want all 0", v0, c0, n0, ov0, sh0, cp0); end
    step(0, 1, 10'h01C, 0);
    checks++; if ({v0, c0} !== {1'b1, 8'h61}) begin fails++; $display("FAIL mid_after: valid=%b char=%h want 1/61", v0, c0); end
  endtask

  task automatic test_random();
    logic [7:0] h0, h1;
    step(1, 0, 10'h000, 0);
    for (int i = 0; i < 600; i++) begin
      step(0, $urandom_range(0, 3) != 0, {$urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, pool[$urandom_range(0, 17)]},
           $urandom_range(0, 2) == 0);
      h0 = q0.size() > 0 ? q0[0] : 8'h00;
      h1 = q1.size() > 0 ? q1[0] : 8'h00;
      checks++; if ({v0, c0, n0} !== {q0.size() > 0, h0, 4'(q0.size())}) begin fails++; $display("FAIL rand_q0 @%0d: valid=%b char=%h count=%0d want %b/%h/%0d", i, v0, c0, n0, q0.size() > 0, h0, q0.size()); end
      checks++; if ({v1, c1, n1} !== {q1.size() > 0, h1, 4'(q1.size())}) begin fails++; $display("FAIL rand_q1 @%0d: valid=%b char=%h count=%0d want %b/%h/%0d", i, v1, c1, n1, q1.size() > 0, h1, q1.size()); end
      checks++; if ({ov0, ov1, sh0, cp0} !== {m_ov0, m_ov1, m_ls | m_rs, m_caps}) begin fails++; $display("FAIL rand_flags @%0d: ovf=%b%b shift=%b caps=%b want %b%b/%b/%b", i, ov0, ov1, sh0, cp0, m_ov0, m_ov1, m_ls | m_rs, m_caps); end
    end
  endtask

  initial begin
    string letters = "abcdefghijklmnopqrstuvwxyz";
    for (int i = 0; i < 26; i++) lower_tbl[int'(letter_sc[i])] = letters[i];
    for (int i = 0; i < 10; i++) lower_tbl[int'(digit_sc[i])] = 8'h30 + 8'(i);
    lower_tbl['h29] = 8'h20;
    lower_tbl['h5A] = 8'h0D;
    lower_tbl['h66] = 8'h08;
    lower_tbl['h76] = 8'h1B;
    model_reset();
    test_reset();
    test_basic();
    test_shift_caps();
    test_repeat();
    test_ext();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/scan_ascii_fifo.md
Name: scan_ascii_fifo

Overview:
- Successor to the fixed-table scan-to-ASCII converter.
- Accepts strobed PS/2 key events in the 10-bit form {ext, brk, scan[7:0]}.
- Tracks Shift and Caps Lock, translates make codes to ASCII (upper or lower case, shifted digit symbols), and filters typematic repeats.
- Queues characters in a parametrised first-word-fall-through FIFO with a valid/ready output for the game or text logic.

Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW; legal range 1..6.
- UPPER_EN, 1: 1 enables Shift/Caps case and symbol mapping; 0 always produces the unshifted table.
- REPEAT_FILTER, 1: 1 drops repeated make codes of a held key; 0 enqueues every make.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code is sampled on the edge where this is high.
- code  in  10  [9] extended (E0), [8] break (F0), [7:0] scan code.
- char_ready  in  1  consumer accepts the head character this cycle.
- char_valid  out  1  FIFO non-empty.
- char  out  8  head character; 8'h00 whenever char_valid=0.
- fifo_count  out  FIFO_AW+1  number of stored characters, 0..2**FIFO_AW.
- overflow  out  1  sticky; set when a character is dropped because the FIFO is full.
- shift_state  out  1  left or right Shift currently held.
- caps_state  out  1  Caps Lock toggle state.

Behaviour:
- Reset, synchronous (rst high at an edge):
  - char_valid=0, char=00, fifo_count=0, overflow=0, shift_state=0, caps_state=0.
  - Held-key register cleared; FIFO pointers = 0.
  - rst overrides all same-cycle input and pop activity.
  - Reset mid-stream discards all queued characters.
- Input:
  - No backpressure; one event is processed per edge with code_valid=1.
  - code is ignored when code_valid=0.
  - code[9:8]=2'b11 (extended break) is handled as a break.
- Modifiers (non-extended only); modifier events are never enqueued:
  - 0x12 or 0x59 make sets the respective shift flag; its break clears it.
  - shift_state = OR of the two flags.
  - 0x58 make toggles caps_state, but only if 0x58 is not already the held key.
- Translation, unshifted:
  - Space 20, Enter 0D, Backspace 08, Esc 1B.
  - 0-9 map to 30-39.
  - A-Z map to 61-7A.
  - Extended Right 1C, Left 1D, Up 1E, Down 1F.
- Translation, UPPER_EN=1:
  - Letters use 41-5A when (shift_state XOR caps_state)=1.
  - Digits with shift_state=1 map 1..9,0 to 21,40,23,24,25,5E,26,2A,28,29; Caps does not affect digits.
  - Other keys are unaffected.
- Modifier state used for translation is the value before the current event's edge.
- Unmapped make codes and all break codes are not enqueued. No 00 character is ever written.
- Repeat filter, REPEAT_FILTER=1:
  - held = {valid, ext, scan}.
  - A make equal to held is dropped (also blocks a Caps re-toggle).
  - A different make, including a modifier, replaces held.
  - A break matching held clears valid.
- Latency: an accepted make at edge E is written at edge E. char_valid and char reflect it from the cycle after E if the FIFO was empty, so the latency is 1 cycle.
- FIFO:
  - Pop occurs at an edge with char_valid=1 and char_ready=1.
  - char_ready with an empty FIFO has no effect.
  - Push when not full: written, count+1.
  - Simultaneous push and pop: count unchanged, ordering preserved; legal when full, since the push uses the slot being freed.
  - Simultaneous push and pop on an empty FIFO: no pop; the push lands.
  - Push when full with no pop: character dropped, overflow=1 until reset.
  - Pointers wrap modulo depth.

Test Plan:
- Reset then code_valid with 0x1C -> one cycle later char_valid=1, char=61, fifo_count=1; char_ready=1 -> char_valid=0, char=00.
- Sequence 0x012 make, 0x01C, 0x11C (break), 0x112 (Shift break), 0x01C -> chars 41 then 61. Then 0x058 make, 0x158, 0x016 -> char 31 with caps_state=1. Then 0x012, 0x016 -> char 21.
- 0x01D three times (typematic), then 0x11D, then 0x01D -> exactly two 77 characters. Same sequence with REPEAT_FILTER=0 -> four 77 characters.
- Extended 0x274 -> 1C; 0x275 -> 1E; 0x374 -> nothing enqueued. Unmapped 0x00E -> nothing enqueued.
- FIFO_AW=3, char_ready=0, nine distinct makes -> fifo_count=8, overflow=1, ninth character lost. Then push with char_ready=1 while full -> count stays 8, order intact.
- rst asserted with 5 queued characters, shift_state=1, caps_state=1 -> next cycle all outputs zero. A following 0x01C yields 61.
